// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the RV32I load/store port.
// Accepts one request at a time (req_valid/req_ready), waits WAIT_CYCLES
// cycles, performs the byte-lane store or extended load selected by funct3,
// and returns the result on a response handshake (rsp_valid/rsp_ready).
//
// Parameters: DEPTH (32-bit words, power of two, >= 4), WAIT_CYCLES (0-15).
// Ports:
//   clk, reset (synchronous, active-high)
//   req_valid/req_ready, req_we, req_funct3[2:0], req_addr[31:0], req_wdata[31:0]
//   rsp_valid/rsp_ready, rsp_rdata[31:0], rsp_err
//   busy: a request is in flight
// Optional feature: define DMEM_MISALIGN_TRAP_EN to report misaligned
// halfword/word accesses as errors instead of silently aligning them.
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_next;
  logic [3:0]    cnt;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          acc_fire;
  logic          acc_we;
  logic [2:0]    acc_f3;
  logic [AW+1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic [1:0]    acc_off;
  logic          acc_bad;
  logic [3:0]    acc_be;
  logic [31:0]   acc_wword;
  logic [31:0]   acc_rword;
  logic [31:0]   acc_shift;
  logic [31:0]   acc_load;

  // Upper address bits are don't-care: addresses wrap modulo DEPTH*4.
  logic addr_unused;
  assign addr_unused = ^req_addr[31:AW+2];

  assign accept = (state == IDLE) && req_valid;

  // With zero wait states the access happens on the accept edge, so the
  // live request fields are used; otherwise the latched copy is used.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = req_we;
      acc_f3    = req_funct3;
      acc_addr  = req_addr[AW+1:0];
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_f3    = f3_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  always_comb begin
    if (WAIT_CYCLES == 0) acc_fire = accept;
    else                  acc_fire = (state == WAIT) && (cnt == 4'd1);
  end

  // Access decode: validity, lane offset, byte enables and load extension.
  always_comb begin
    acc_bad = acc_we ? (acc_f3 > 3'd2) : ((acc_f3 == 3'd3) || (acc_f3[2:1] == 2'b11));
    acc_off = acc_addr[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((acc_f3[1:0] == 2'd1) && acc_off[0])      acc_bad = 1'b1;
    if ((acc_f3[1:0] == 2'd2) && (acc_off != '0)) acc_bad = 1'b1;
`else
    if (acc_f3[1:0] == 2'd1) acc_off[0] = 1'b0;
    if (acc_f3[1:0] == 2'd2) acc_off    = '0;
`endif
    acc_idx = acc_addr[AW+1:2];
    case (acc_f3[1:0])
      2'd0:    begin acc_be = 4'b0001 << acc_off; acc_wword = {4{acc_wdata[7:0]}};  end
      2'd1:    begin acc_be = 4'b0011 << acc_off; acc_wword = {2{acc_wdata[15:0]}}; end
      default: begin acc_be = 4'b1111;            acc_wword = acc_wdata;            end
    endcase
    acc_rword = mem[acc_idx];
    acc_shift = acc_rword >> {acc_off, 3'b000};
    case (acc_f3)
      3'b000:  acc_load = {{24{acc_shift[7]}}, acc_shift[7:0]};
      3'b001:  acc_load = {{16{acc_shift[15]}}, acc_shift[15:0]};
      3'b010:  acc_load = acc_rword;
      3'b100:  acc_load = {24'd0, acc_shift[7:0]};
      3'b101:  acc_load = {16'd0, acc_shift[15:0]};
      default: acc_load = '0;
    endcase
  end

  // Memory array has no reset; reset only gates a pending write.
  always_ff @(posedge clk) begin
    if (!reset && acc_fire && acc_we && !acc_bad) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wword[8*i +: 8];
      end
    end
  end

  // State register plus request latch, counter and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr[AW+1:0];
        wdata_q <= req_wdata;
        cnt     <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (acc_fire) begin
        rsp_rdata <= (acc_we || acc_bad) ? '0 : acc_load;
        rsp_err   <= acc_bad;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd1) state_next = RESP;
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances with WAIT_CYCLES of
// 2, 0 and 5 run directed test-plan cases and randomized traffic against a
// byte-array reference model.
module tb_dmem_responder;

  localparam int N = 3;
  localparam int WC [N] = '{2, 0, 5};

  logic        clk;
  logic        reset;
  logic        req_valid  [N];
  logic        req_ready  [N];
  logic        req_we     [N];
  logic [2:0]  req_funct3 [N];
  logic [31:0] req_addr   [N];
  logic [31:0] req_wdata  [N];
  logic        rsp_valid  [N];
  logic        rsp_ready  [N];
  logic [31:0] rsp_rdata  [N];
  logic        rsp_err    [N];
  logic        busy       [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_responder #(
      .DEPTH(64),
      .WAIT_CYCLES(WC[g])
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we(req_we[g]),
      .req_funct3(req_funct3[g]),
      .req_addr(req_addr[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err(rsp_err[g]),
      .busy(busy[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  logic [7:0] mdl [N][256];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed memory of DEPTH*4 = 256 bytes.
  task automatic model_op(input int k, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic err);
    int size;
    int base;
    logic [31:0] v;
    err  = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    base = int'(addr % 256);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (base % size != 0) err = 1'b1;
`else
    base = base - (base % size);
`endif
    rd = '0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) mdl[k][base+i] = 8'(wdata >> (8*i));
      end else begin
        v = '0;
        for (int i = 0; i < size; i++) v = v | (32'(mdl[k][base+i]) << (8*i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
        rd = v;
      end
    end
  endtask

  task automatic check_reset(input int k);
    check_eq("rst_req_ready", 32'(req_ready[k]), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata[k], 32'd0);
    check_eq("rst_rsp_err",   32'(rsp_err[k]), 32'd0);
    check_eq("rst_busy",      32'(busy[k]), 32'd0);
  endtask

  // Entered and left #1 after a rising edge with the instance idle.
  task automatic txn(input int k, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata, input int bp,
                     output logic [31:0] rd, output logic err);
    logic [31:0] exp_rd;
    logic exp_err;
    int lat;
    model_op(k, we, f3, addr, wdata, exp_rd, exp_err);
    check_eq("idle_ready", 32'(req_ready[k]), 32'd1);
    req_valid[k]  = 1'b1;
    req_we[k]     = we;
    req_funct3[k] = f3;
    req_addr[k]   = addr;
    req_wdata[k]  = wdata;
    @(posedge clk); #1;
    // Scramble the request bus: only the latched copy may matter.
    req_valid[k]  = 1'b0;
    req_we[k]     = 1'($urandom);
    req_funct3[k] = 3'($urandom);
    req_addr[k]   = $urandom;
    req_wdata[k]  = $urandom;
    lat = 0;
    while (rsp_valid[k] !== 1'b1 && lat < 40) begin
      check_eq("busy_wait", 32'(busy[k]), 32'd1);
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(WC[k]));
    check_eq("rsp_rdata", rsp_rdata[k], exp_rd);
    check_eq("rsp_err", 32'(rsp_err[k]), 32'(exp_err));
    rd  = rsp_rdata[k];
    err = rsp_err[k];
    repeat (bp) begin
      req_valid[k]  = 1'b1;
      req_we[k]     = 1'b1;
      req_funct3[k] = 3'b010;
      req_addr[k]   = 32'h3C;
      req_wdata[k]  = $urandom;
      @(posedge clk); #1;
      check_eq("bp_valid", 32'(rsp_valid[k]), 32'd1);
      check_eq("bp_rdata", rsp_rdata[k], exp_rd);
      check_eq("bp_err", 32'(rsp_err[k]), 32'(exp_err));
      check_eq("bp_ready", 32'(req_ready[k]), 32'd0);
    end
    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
    check_eq("post_valid", 32'(rsp_valid[k]), 32'd0);
    check_eq("post_ready", 32'(req_ready[k]), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    logic we;
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_funct3[k] = '0;
      req_addr[k] = '0; req_wdata[k] = '0; rsp_ready[k] = 1'b0;
      for (int a = 0; a < 256; a++) mdl[k][a] = 8'h00;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < N; k++) check_reset(k);

    // sw then lw
    txn(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er);
    txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
    check_eq("lw_0x10", rd, 32'hDEADBEEF);

    // byte lanes
    txn(0, 1'b1, 3'b010, 32'h20, 32'h0, 0, rd, er);
    txn(0, 1'b1, 3'b000, 32'h21, 32'h80, 0, rd, er);
    txn(0, 1'b1, 3'b001, 32'h22, 32'hABCD, 0, rd, er);
    txn(0, 1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er);
    check_eq("lw_0x20", rd, 32'hABCD8000);
    txn(0, 1'b0, 3'b000, 32'h21, 32'h0, 0, rd, er);
    check_eq("lb_0x21", rd, 32'hFFFFFF80);
    txn(0, 1'b0, 3'b100, 32'h21, 32'h0, 0, rd, er);
    check_eq("lbu_0x21", rd, 32'h00000080);
    txn(0, 1'b0, 3'b001, 32'h22, 32'h0, 0, rd, er);
    check_eq("lh_0x22", rd, 32'hFFFFABCD);

    // back-pressure with ignored store pulses to 0x3C
    txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 5, rd, er);
    txn(0, 1'b0, 3'b010, 32'h3C, 32'h0, 0, rd, er);
    check_eq("bp_no_store", rd, 32'h0);

    // reset on the access edge of sw 0x55 to 0x30
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'b010;
    req_addr[0] = 32'h30; req_wdata[0] = 32'h55;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset(0);
    txn(0, 1'b0, 3'b010, 32'h30, 32'h0, 0, rd, er);
    check_eq("rst_no_write", rd, 32'h0);

    // invalid store code, then misaligned word load
    txn(0, 1'b1, 3'b100, 32'h10, 32'h11111111, 0, rd, er);
    check_eq("inv_store_err", 32'(er), 32'd1);
    txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
    check_eq("inv_store_nowr", rd, 32'hDEADBEEF);
    txn(0, 1'b0, 3'b010, 32'h13, 32'h0, 0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    check_eq("lw_0x13_err", 32'(er), 32'd1);
    check_eq("lw_0x13_rd", rd, 32'h0);
`else
    check_eq("lw_0x13_err", 32'(er), 32'd0);
    check_eq("lw_0x13_rd", rd, 32'hDEADBEEF);
`endif

    // address wrap on every latency configuration
    for (int k = 0; k < N; k++) begin
      txn(k, 1'b1, 3'b010, 32'h100, 32'd7, 0, rd, er);
      txn(k, 1'b0, 3'b010, 32'h0, 32'h0, 0, rd, er);
      check_eq("wrap_lw_0", rd, 32'd7);
    end

    // randomized traffic
    for (int k = 0; k < N; k++) begin
      for (int n = 0; n < 150; n++) begin
        we = 1'($urandom);
        txn(k, we, we ? 3'($urandom_range(0, 3)) : 3'($urandom), $urandom,
            $urandom, int'($urandom_range(0, 2)), rd, er);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout got=0x%08h exp=0x%08h", 32'd0, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V core: the memory end of the CPU's load/store port. It accepts one request at a time through a valid/ready handshake, inserts a configurable number of wait states, and performs the byte-lane store or the sign/zero-extended load selected by the RV32I funct3. It then returns a response through a second valid/ready handshake. It replaces the zero-latency array behind the CPU's data address, write-data and read-data signals with a multi-cycle memory the core must wait on.

## Interface
- `DEPTH`, default 64: memory size in 32-bit words; power of two, ≥ 4.
- `WAIT_CYCLES`, default 2: wait states between accept and access; 0–15.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width/sign code.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  requester takes the response.
- `rsp_rdata`  out  32  load result, already extended.
- `rsp_err`  out  1  request was rejected; no memory side effect.
- `busy`  out  1  request in flight (state is not IDLE).

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - Handshake (`req_valid`&`req_ready`): latch `req_we`, `req_funct3`, `req_addr` and `req_wdata`; load the counter with `WAIT_CYCLES`.
  - Next state is WAIT, or RESP when `WAIT_CYCLES`=0.
- **WAIT**
  - Counter decrements each cycle.
  - When the counter is 1, access is performed at that edge and the next state is RESP.
- **Access**
  - With `WAIT_CYCLES`=0, access is performed on the accept edge.
  - Write effects happen exactly once, in the same edge that enters RESP; the response registers are loaded in that edge too.
- **RESP**
  - `rsp_valid`=1.
  - `rsp_rdata` and `rsp_err` are held stable until `rsp_ready`=1. Then go to IDLE.
  - `req_ready`=0 during RESP; there is no accept in the same cycle as the response handshake.
- **Word index**: `req_addr[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo DEPTH×4.
- **Stores** (`req_we`=1)
  - funct3 000 (sb): write `wdata[7:0]` to lane `addr[1:0]`.
  - funct3 001 (sh): write `wdata[15:0]` to lanes {`addr[1]`,0} and {`addr[1]`,1}.
  - funct3 010 (sw): write all four lanes.
  - Other lanes are untouched. `rsp_rdata`=0.
- **Loads** (`req_we`=0)
  - 000 lb: sign-extend the selected byte.
  - 001 lh: sign-extend the selected halfword.
  - 010 lw: full word.
  - 100 lbu, 101 lhu: zero-extend.
- **Invalid funct3**
  - Stores: any code other than 000/001/010.
  - Loads: 011, 110, 111.
  - Response: `rsp_err`=1, `rsp_rdata`=0, no write. The normal latency is still used.
- **Memory array**: not cleared by reset; simulation initialises it to 0.

## Timing
- **Reset values**: state IDLE, counter 0, `req_ready`=1 (first cycle after reset deasserts), `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0.
- **Latency**: accept at edge t gives `rsp_valid` high in the cycle after edge t+`WAIT_CYCLES`. Minimum is 1 cycle; the default is 3.
- **Throughput**: one request per `WAIT_CYCLES`+2 cycles when `rsp_ready` is tied 1.
- **Back-pressure**: `rsp_ready`=0 holds RESP indefinitely with outputs frozen; incoming `req_valid` is ignored.
- **Reset mid-operation**: reset has priority over everything. A reset in the access cycle suppresses the write. Any pending request and response are discarded.
- **Request changes while not ready**: changes on `req_*` while `req_ready`=0 have no effect. Only the latched copy is used.

## Configuration
- `DMEM_MISALIGN_TRAP_EN`
  - Defined: an access is misaligned when sh/lh/lhu has `addr[0]`=1, or sw/lw has `addr[1:0]`≠0. A misaligned access sets `rsp_err`=1, `rsp_rdata`=0 and performs no write.
  - Undefined: misaligned low address bits are cleared (halfword: `addr[0]`; word: `addr[1:0]`), the access proceeds aligned, and `rsp_err` only reports an invalid funct3.

## Test plan
- **Reset, sw, then lw**: reset 2 cycles; sw 0xDEADBEEF to 0x10, then lw 0x10.
  - Required: `rsp_valid` 3 cycles after each accept; `rsp_rdata`=0xDEADBEEF and `rsp_err`=0 on the load.
- **Byte lanes**: sw 0 to 0x20; sb 0x80 to 0x21; sh 0xABCD to 0x22.
  - Required: lw 0x20 → 0xABCD8000; lb 0x21 → 0xFFFFFF80; lbu 0x21 → 0x00000080; lh 0x22 → 0xFFFFABCD.
- **Back-pressure**: `rsp_ready`=0 for 5 cycles on a lw; `req_valid` pulsed during that window.
  - Required: `rsp_valid` and `rsp_rdata` stay stable; the second request is not accepted; accept resumes in the cycle after the response handshake.
- **Reset during WAIT**: reset asserted in the access cycle of sw 0x55 to 0x30.
  - Required: a later lw 0x30 returns the prior value 0; outputs are at their reset values.
- **Invalid funct3 and misalignment**: store with funct3=100; lw 0x13 with macro defined and undefined.
  - Required: the store gives `rsp_err`=1 and memory is unchanged. lw 0x13 gives `err`=1 with the macro defined, and returns word 0x10 with `err`=0 without it.
- **Wrap and latency sweep**: with DEPTH=64, sw 7 to 0x100; `WAIT_CYCLES`=0 and 5.
  - Required: lw 0x0 → 7; response latency is 1 and 6 cycles respectively.
